// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight: accept in IDLE, hand off to memory in ISSUE, route the response in WAIT.
module mem_port_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_resp_valid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  ls_req_valid,
   output logic                  ls_req_ready,
   input  logic [ADDR_W-1:0]     ls_addr,
   input  logic                  ls_wen,
   input  logic [DATA_W-1:0]     ls_wdata,
   input  logic [DATA_W/8-1:0]   ls_wmask,
   output logic                  ls_resp_valid,
   output logic [DATA_W-1:0]     ls_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic                  owner,
   output logic                  err
);

   localparam int MASK_W = DATA_W / 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wen_q, mem_wen_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
   logic              if_resp_valid_q, if_resp_valid_d;
   logic              ls_resp_valid_q, ls_resp_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              err_q, err_d;
   logic              grant_if_s, grant_ls_s;

   // Grant: a lone requester wins; on a tie the one not granted last wins (last_q = 1 means LS went last).
   always_comb begin
      grant_if_s = 1'b0;
      grant_ls_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (if_req_valid && ls_req_valid) begin
            if (last_q) begin
               grant_if_s = 1'b1;
            end else begin
               grant_ls_s = 1'b1;
            end
         end else if (if_req_valid) begin
            grant_if_s = 1'b1;
         end else if (ls_req_valid) begin
            grant_ls_s = 1'b1;
         end else begin
            grant_if_s = 1'b0;
         end
      end else begin
         grant_ls_s = 1'b0;
      end
   end

   // Next-state computation for the FSM, latched request and routed response.
   always_comb begin
      state_d         = state_q;
      last_d          = last_q;
      owner_d         = owner_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      mem_wen_d       = mem_wen_q;
      mem_wdata_d     = mem_wdata_q;
      mem_wmask_d     = mem_wmask_q;
      if_resp_valid_d = 1'b0;
      ls_resp_valid_d = 1'b0;
      if_rdata_d      = if_rdata_q;
      ls_rdata_d      = ls_rdata_q;
      // A response outside WAIT is a protocol violation and is otherwise dropped.
      err_d           = err_q | (mem_resp_valid && (state_q != ST_WAIT));
      case (state_q)
         ST_IDLE: begin
            if (grant_if_s) begin
               mem_addr_d      = if_addr;
               mem_wen_d       = 1'b0;
               mem_wdata_d     = {DATA_W{1'b0}};
               mem_wmask_d     = {MASK_W{1'b0}};
               owner_d         = 1'b0;
               last_d          = 1'b0;
               mem_req_valid_d = 1'b1;
               state_d         = ST_ISSUE;
            end else if (grant_ls_s) begin
               mem_addr_d      = ls_addr;
               mem_wen_d       = ls_wen;
               mem_wdata_d     = ls_wdata;
               mem_wmask_d     = ls_wen ? ls_wmask : {MASK_W{1'b0}};
               owner_d         = 1'b1;
               last_d          = 1'b1;
               mem_req_valid_d = 1'b1;
               state_d         = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_d = ST_IDLE;
               if (owner_q) begin
                  ls_resp_valid_d = 1'b1;
                  ls_rdata_d      = mem_wen_q ? {DATA_W{1'b0}} : mem_rdata;
               end else begin
                  if_resp_valid_d = 1'b1;
                  if_rdata_d      = mem_rdata;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d         = ST_IDLE;
            mem_req_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset leaves last = LS so IF wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         last_q          <= 1'b1;
         owner_q         <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= {ADDR_W{1'b0}};
         mem_wen_q       <= 1'b0;
         mem_wdata_q     <= {DATA_W{1'b0}};
         mem_wmask_q     <= {MASK_W{1'b0}};
         if_resp_valid_q <= 1'b0;
         ls_resp_valid_q <= 1'b0;
         if_rdata_q      <= {DATA_W{1'b0}};
         ls_rdata_q      <= {DATA_W{1'b0}};
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_q          <= last_d;
         owner_q         <= owner_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wen_q       <= mem_wen_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wmask_q     <= mem_wmask_d;
         if_resp_valid_q <= if_resp_valid_d;
         ls_resp_valid_q <= ls_resp_valid_d;
         if_rdata_q      <= if_rdata_d;
         ls_rdata_q      <= ls_rdata_d;
         err_q           <= err_d;
      end
   end

   assign if_req_ready  = grant_if_s;
   assign ls_req_ready  = grant_ls_s;
   assign if_resp_valid = if_resp_valid_q;
   assign if_rdata      = if_rdata_q;
   assign ls_resp_valid = ls_resp_valid_q;
   assign ls_rdata      = ls_rdata_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wen       = mem_wen_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign busy          = (state_q != ST_IDLE);
   assign owner         = owner_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model (one pending-transaction record, round-robin rule, sticky error).
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req_valid, if_req_ready;
   logic [63:0] if_addr;
   logic        if_resp_valid;
   logic [63:0] if_rdata;
   logic        ls_req_valid, ls_req_ready;
   logic [63:0] ls_addr;
   logic        ls_wen;
   logic [63:0] ls_wdata;
   logic [7:0]  ls_wmask;
   logic        ls_resp_valid;
   logic [63:0] ls_rdata;
   logic        mem_req_valid, mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_rdata;
   logic        busy, owner, err;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a single pending-transaction record plus the visible response state.
   bit        m_pend, m_pend_ls, m_issued, m_last_ls, m_owner, m_err;
   bit        m_if_rv, m_ls_rv;
   bit [63:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
   bit        m_wen;
   bit [7:0]  m_wmask;
   bit        grant_log[$];

   task automatic model_reset();
      m_pend = 0; m_pend_ls = 0; m_issued = 0; m_last_ls = 1; m_owner = 0; m_err = 0;
      m_if_rv = 0; m_ls_rv = 0; m_addr = 64'd0; m_wdata = 64'd0; m_wen = 0; m_wmask = 8'd0;
      m_if_rdata = 64'd0; m_ls_rdata = 64'd0;
   endtask

   // 0 = nobody, 1 = IF, 2 = LS, according to the round-robin rule
   function automatic int winner();
      if (m_pend) return 0;
      if (if_req_valid && ls_req_valid) return m_last_ls ? 1 : 2;
      if (if_req_valid) return 1;
      if (ls_req_valid) return 2;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int w;
      w = winner();
      chk("if_req_ready", 64'(if_req_ready), 64'(w == 1));
      chk("ls_req_ready", 64'(ls_req_ready), 64'(w == 2));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(m_pend && !m_issued));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", 64'(mem_wen), 64'(m_wen));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
      chk("if_resp_valid", 64'(if_resp_valid), 64'(m_if_rv));
      chk("ls_resp_valid", 64'(ls_resp_valid), 64'(m_ls_rv));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("ls_rdata", ls_rdata, m_ls_rdata);
      chk("busy", 64'(busy), 64'(m_pend));
      chk("owner", 64'(owner), 64'(m_owner));
      chk("err", 64'(err), 64'(m_err));
   endtask

   // Advance the model across one rising edge using the inputs applied during the cycle.
   task automatic model_step();
      int  w;
      bit  pend0, issued0;
      w = winner();
      pend0 = m_pend; issued0 = m_issued;
      m_if_rv = 0; m_ls_rv = 0;
      if (mem_resp_valid) begin
         if (pend0 && issued0) begin
            if (m_pend_ls) begin
               m_ls_rv = 1;
               m_ls_rdata = m_wen ? 64'd0 : mem_rdata;
            end else begin
               m_if_rv = 1;
               m_if_rdata = mem_rdata;
            end
            m_pend = 0;
         end else begin
            m_err = 1;
         end
      end
      if (mem_req_ready && pend0 && !issued0) m_issued = 1;
      if (w == 1) begin
         m_pend = 1; m_pend_ls = 0; m_issued = 0; m_last_ls = 0; m_owner = 0;
         m_addr = if_addr; m_wen = 0; m_wdata = 64'd0; m_wmask = 8'd0;
         grant_log.push_back(1'b0);
      end else if (w == 2) begin
         m_pend = 1; m_pend_ls = 1; m_issued = 0; m_last_ls = 1; m_owner = 1;
         m_addr = ls_addr; m_wen = ls_wen; m_wdata = ls_wdata; m_wmask = ls_wen ? ls_wmask : 8'd0;
         grant_log.push_back(1'b1);
      end
   endtask

   // mode 0: memory inputs as set by caller, 1: zero-wait memory, 2: random-latency memory
   task automatic tick(input int mode);
      if (mode == 1) begin
         mem_req_ready  = 1'b1;
         mem_resp_valid = m_pend && m_issued;
         mem_rdata      = {$urandom, $urandom};
      end else if (mode == 2) begin
         mem_req_ready  = ($urandom_range(0, 2) != 0);
         mem_resp_valid = m_pend && m_issued && ($urandom_range(0, 1) == 1);
         mem_rdata      = {$urandom, $urandom};
      end
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      if_req_valid = 0; if_addr = 64'd0;
      ls_req_valid = 0; ls_addr = 64'd0; ls_wen = 0; ls_wdata = 64'd0; ls_wmask = 8'd0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 64'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ifs, lss;
      rst_n = 1'b0;
      clear_inputs();
      do_reset();

      // IF-only fetch, memory ready at once, response one cycle later
      if_req_valid = 1; if_addr = 64'h0000_0000_8000_0000;
      tick(0);
      if_req_valid = 0; if_addr = 64'h1234; mem_req_ready = 1;
      tick(0);
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h0000_0000_0010_0093;
      tick(0);
      mem_resp_valid = 0; mem_rdata = 64'hFFFF;
      tick(0);
      chk("tp1_if_rdata", if_rdata, 64'h0000_0000_0010_0093);
      chk("tp1_addr", mem_addr, 64'h0000_0000_8000_0000);

      // Both held valid, zero-wait memory: grants alternate starting with IF
      do_reset();
      grant_log.delete();
      if_req_valid = 1; ls_req_valid = 1; if_addr = 64'h100; ls_addr = 64'h200;
      for (int i = 0; i < 12; i++) tick(1);
      chk("tp2_grant_count", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk("tp2_grant_order", 64'(grant_log[i]), 64'(i % 2));
      if_req_valid = 0; ls_req_valid = 0;
      for (int i = 0; i < 4; i++) tick(1);

      // LS write with mem_req_ready held off for 4 cycles
      clear_inputs();
      ls_req_valid = 1; ls_addr = 64'h0000_0000_8000_1000; ls_wen = 1;
      ls_wdata = 64'hDEAD_BEEF_CAFE_F00D; ls_wmask = 8'h0F;
      tick(0);
      ls_req_valid = 0; ls_addr = 64'h5555; ls_wen = 0; ls_wdata = 64'h0; ls_wmask = 8'hFF;
      for (int i = 0; i < 4; i++) tick(0);
      mem_req_ready = 1;
      tick(0);
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      tick(0);
      mem_resp_valid = 0;
      tick(0);
      chk("tp3_ls_rdata", ls_rdata, 64'd0);
      chk("tp3_wmask", 64'(mem_wmask), 64'h0F);
      chk("tp3_wen", 64'(mem_wen), 64'd1);

      // LS read with full mask: mask must be latched as zero
      clear_inputs();
      ls_req_valid = 1; ls_addr = 64'h0000_0000_8000_2000; ls_wen = 0; ls_wmask = 8'hFF;
      tick(0);
      chk("tp4_wmask", 64'(mem_wmask), 64'h00);
      ls_req_valid = 0; mem_req_ready = 1;
      tick(0);
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
      tick(0);
      mem_resp_valid = 0;
      tick(0);
      chk("tp4_ls_rdata", ls_rdata, 64'h0123_4567_89AB_CDEF);

      // Reset while in WAIT, stale response after release
      clear_inputs();
      ls_req_valid = 1; ls_addr = 64'h300;
      tick(0);
      ls_req_valid = 0; mem_req_ready = 1;
      tick(0);
      mem_req_ready = 0;
      tick(0);
      do_reset();
      tick(0);
      tick(0);
      mem_resp_valid = 1; mem_rdata = 64'h77;
      tick(0);
      mem_resp_valid = 0;
      for (int i = 0; i < 3; i++) tick(0);
      chk("tp5_err_sticky", 64'(err), 64'd1);
      chk("tp5_no_ls_resp", 64'(ls_resp_valid), 64'd0);

      // Response in IDLE with nothing outstanding
      do_reset();
      mem_resp_valid = 1;
      tick(0);
      mem_resp_valid = 0;
      tick(0);
      chk("tp6_err", 64'(err), 64'd1);
      chk("tp6_busy", 64'(busy), 64'd0);

      // Randomized traffic with random memory latency
      do_reset();
      ifs = 0; lss = 0;
      for (int i = 0; i < 600; i++) begin
         if_req_valid = ($urandom_range(0, 2) != 0);
         ls_req_valid = ($urandom_range(0, 2) != 0);
         if_addr  = {$urandom, $urandom};
         ls_addr  = {$urandom, $urandom};
         ls_wen   = $urandom_range(0, 1);
         ls_wdata = {$urandom, $urandom};
         ls_wmask = 8'($urandom);
         if (if_resp_valid) ifs++;
         if (ls_resp_valid) lss++;
         tick(2);
      end
      clear_inputs();
      for (int i = 0; i < 20; i++) tick(2);
      chk("rand_if_served", 64'(ifs > 0), 64'd1);
      chk("rand_ls_served", 64'(lss > 0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
